// File: rtl/h2bp_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package h2bp;

  typedef logic [31:0] instr_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam instr_t      NOP_INSTR = 32'b0;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry hold register: keeps the instruction decode refused while the
// memory output register (no enable) moves on underneath it.
module fetch_hold_buf
  import h2bp::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic                gclk,
  input  logic                grst_n,
  input  logic                capture_i,
  input  logic                release_i,
  input  instr_t              instr_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output instr_t              instr_o,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                valid_o
);

  instr_t              instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                valid_q, valid_d;

  // Release wins over capture; a capture while already full keeps the original.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (release_i) begin
      valid_d = 1'b0;
    end else if (capture_i && !valid_q) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, redirect muxing, and realignment
// of the 1-cycle-latency memory return with its PC, with a stall hold buffer.
module fetch_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(h2bp::RESET_PC),
  parameter int                  PC_INC   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                branch_i,
  input  logic [PC_WIDTH-1:0] branch_target_i,
  input  logic                jump_i,
  input  logic [PC_WIDTH-1:0] jump_target_i,
  output logic [PC_WIDTH-1:0] pc_o,
  input  logic [31:0]         instr_i,
  output logic [31:0]         instr_o,
  output logic [PC_WIDTH-1:0] instr_pc_o,
  output logic                instr_valid_o
);
  import h2bp::*;

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                inflight_valid_q, inflight_valid_d;

  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;

  logic                hold_capture, hold_release, hold_valid;
  instr_t              hold_instr;
  logic [PC_WIDTH-1:0] hold_pc;

  instr_t              pres_instr;
  logic [PC_WIDTH-1:0] pres_pc;
  logic                pres_valid;

  assign redirect    = branch_i | jump_i;
  assign redirect_pc = jump_i ? jump_target_i : branch_target_i;
  assign pc_inc      = pc_q + PC_WIDTH'(PC_INC);

  // The hold buffer shadows the live memory return while it is occupied.
  always_comb begin
    pres_instr = instr_i;
    pres_pc    = inflight_pc_q;
    pres_valid = inflight_valid_q;
    if (hold_valid) begin
      pres_instr = hold_instr;
      pres_pc    = hold_pc;
      pres_valid = 1'b1;
    end
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_valid_d = inflight_valid_q;
    hold_capture     = 1'b0;
    hold_release     = 1'b0;
    if (redirect) begin
      // Memory return is flushed by the same signal, so next cycle is a bubble.
      pc_d             = redirect_pc;
      inflight_valid_d = 1'b0;
      hold_release     = 1'b1;
      state_d          = RUN;
    end else if (stall_i && pres_valid) begin
      // PC frozen; memory re-reads pc_q and those returns are dropped.
      inflight_valid_d = 1'b0;
      hold_capture     = (state_q == RUN);
      state_d          = STALL;
    end else begin
      pc_d             = pc_inc;
      inflight_pc_d    = pc_q;
      inflight_valid_d = 1'b1;
      hold_release     = 1'b1;
      state_d          = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= RUN;
      pc_q             <= RESET_PC;
      inflight_pc_q    <= '0;
      inflight_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_valid_q <= inflight_valid_d;
    end
  end

  fetch_hold_buf #(
    .PC_WIDTH (PC_WIDTH)
  ) u_hold (
    .gclk      (clk),
    .grst_n    (rst),
    .capture_i (hold_capture),
    .release_i (hold_release),
    .instr_i   (pres_instr),
    .pc_i      (pres_pc),
    .instr_o   (hold_instr),
    .pc_o      (hold_pc),
    .valid_o   (hold_valid)
  );

  assign pc_o          = pc_q;
  assign instr_o       = pres_valid ? pres_instr : NOP_INSTR;
  assign instr_pc_o    = pres_pc;
  assign instr_valid_o = pres_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered instruction-memory model.
module tb_fetch_unit;

  logic        clk, rst;
  logic        stall_i, branch_i, jump_i;
  logic [31:0] branch_target_i, jump_target_i;
  logic [31:0] pc_o, instr_i, instr_o, instr_pc_o;
  logic        instr_valid_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        v;
    logic [31:0] ipc;
  } exp_t;
  exp_t sb[$];

  fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .PC_INC(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .pc_o            (pc_o),
    .instr_i         (instr_i),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_valid_o   (instr_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Registered memory with the output register cleared by a redirect flush.
  always @(posedge clk or negedge rst) begin
    if (!rst) instr_i <= 32'h0;
    else      instr_i <= (branch_i | jump_i) ? 32'h0 : mem_f(pc_o);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, required test end");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] pc, input logic v, input logic [31:0] ipc);
    exp_t e;
    e.tag = tag; e.pc = pc; e.v = v; e.ipc = ipc;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, ".pc_o"}, pc_o, e.pc);
    cmp({e.tag, ".valid"}, {31'b0, instr_valid_o}, {31'b0, e.v});
    cmp({e.tag, ".instr"}, instr_o, e.v ? mem_f(e.ipc) : 32'h0);
    if (e.v) cmp({e.tag, ".ipc"}, instr_pc_o, e.ipc);
  endtask

  task automatic step(input logic st, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt, input string tag,
                      input logic [31:0] e_pc, input logic e_v, input logic [31:0] e_ipc);
    stall_i = st; branch_i = br; branch_target_i = bt; jump_i = jp; jump_target_i = jt;
    push(tag, e_pc, e_v, e_ipc);
    @(posedge clk); #1;
    stall_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0;
    check_pop();
  endtask

  initial begin
    rst = 1'b0; stall_i = 0; branch_i = 0; jump_i = 0;
    branch_target_i = 0; jump_target_i = 0;
    @(posedge clk); #1;
    push("reset", 32'h0, 1'b0, 32'h0);
    check_pop();
    cmp("reset.ipc", instr_pc_o, 32'h0);
    rst = 1'b1;

    // Straight-line fetch
    step(0, 0, 0, 0, 0, "run0", 32'd1, 1, 32'd0);
    step(0, 0, 0, 0, 0, "run1", 32'd2, 1, 32'd1);
    step(0, 0, 0, 0, 0, "run2", 32'd3, 1, 32'd2);
    // Three stall cycles while presenting pc 2
    step(1, 0, 0, 0, 0, "stall1", 32'd3, 1, 32'd2);
    step(1, 0, 0, 0, 0, "stall2", 32'd3, 1, 32'd2);
    step(1, 0, 0, 0, 0, "stall3", 32'd3, 1, 32'd2);
    step(0, 0, 0, 0, 0, "unstall0", 32'd4, 1, 32'd3);
    step(0, 0, 0, 0, 0, "unstall1", 32'd5, 1, 32'd4);
    // Jump to 14 from pc 5
    step(0, 0, 0, 1, 32'd14, "jump", 32'd14, 0, 32'd0);
    step(0, 0, 0, 0, 0, "jump_t0", 32'd15, 1, 32'd14);
    step(0, 0, 0, 0, 0, "jump_t1", 32'd16, 1, 32'd15);
    // Simultaneous branch and jump: jump target wins
    step(0, 1, 32'd9, 1, 32'd3, "both", 32'd3, 0, 32'd0);
    step(0, 0, 0, 0, 0, "both_t0", 32'd4, 1, 32'd3);
    step(0, 0, 0, 0, 0, "both_t1", 32'd5, 1, 32'd4);
    // Redirect while holding an instruction
    step(1, 0, 0, 0, 0, "hstall", 32'd5, 1, 32'd4);
    step(1, 1, 32'd7, 0, 0, "hredir", 32'd7, 0, 32'd0);
    // Stall on a bubble does not freeze the PC
    step(1, 0, 0, 0, 0, "bubstall", 32'd8, 1, 32'd7);
    step(0, 0, 0, 0, 0, "hredir_t1", 32'd9, 1, 32'd8);
    // PC wrap at the top of the address space
    step(0, 0, 0, 1, 32'hFFFF_FFFF, "wrapj", 32'hFFFF_FFFF, 0, 32'd0);
    step(0, 0, 0, 0, 0, "wrap0", 32'h0, 1, 32'hFFFF_FFFF);
    step(0, 0, 0, 0, 0, "wrap1", 32'h1, 1, 32'h0);
    // Back-to-back redirects
    step(0, 0, 0, 1, 32'd20, "b2b0", 32'd20, 0, 32'd0);
    step(0, 1, 32'd30, 0, 0, "b2b1", 32'd30, 0, 32'd0);
    step(0, 0, 0, 0, 0, "b2b_t0", 32'd31, 1, 32'd30);
    // Asynchronous reset in the middle of a stall
    step(1, 0, 0, 0, 0, "rstall", 32'd31, 1, 32'd30);
    stall_i = 1'b1;
    #3 rst = 1'b0;
    #1;
    push("async_rst", 32'h0, 1'b0, 32'h0);
    check_pop();
    cmp("async_rst.ipc", instr_pc_o, 32'h0);
    stall_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    step(0, 0, 0, 0, 0, "post_rst", 32'd1, 1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
